// File: rtl/board_pkg.sv
// Shared board geometry and FSM encoding for board_ctrl,
// block_locator and the renderer.
package board_pkg;

  localparam logic [10:0] HOR1 = 11'd112;
  localparam logic [10:0] HOR2 = 11'd262;
  localparam logic [10:0] HOR3 = 11'd412;
  localparam logic [10:0] HOR4 = 11'd562;
  localparam logic [10:0] VER1 = 11'd60;
  localparam logic [10:0] VER2 = 11'd130;
  localparam logic [10:0] VER3 = 11'd200;
  localparam logic [10:0] VER4 = 11'd270;
  localparam logic [10:0] B_WIDTH  = 11'd100;
  localparam logic [10:0] B_HEIGHT = 11'd50;

  localparam int NBLOCKS = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOOKUP,
    S_RESP
  } state_t;

  function automatic logic in_span(
    input logic [10:0] v,
    input logic [10:0] lo,
    input logic [10:0] w
  );
    return (v >= lo) && (v <= lo + w);
  endfunction

  function automatic logic [10:0] hor(input logic [1:0] c);
    logic [10:0] r;
    unique case (c)
      2'd0: r = HOR1;
      2'd1: r = HOR2;
      2'd2: r = HOR3;
      default: r = HOR4;
    endcase
    return r;
  endfunction

  function automatic logic [10:0] ver(input logic [1:0] r);
    logic [10:0] v;
    unique case (r)
      2'd0: v = VER1;
      2'd1: v = VER2;
      2'd2: v = VER3;
      default: v = VER4;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/board_ctrl_if.sv
// Hit request/response handshake between collision
// logic (master) and board_ctrl (slave).
interface board_ctrl_if;

  logic        hit_req;
  logic [10:0] hit_x;
  logic [10:0] hit_y;
  logic        hit_ack;
  logic        hit_valid;
  logic [3:0]  hit_idx;

  modport master (
    output hit_req,
    output hit_x,
    output hit_y,
    input  hit_ack,
    input  hit_valid,
    input  hit_idx
  );

  modport slave (
    input  hit_req,
    input  hit_x,
    input  hit_y,
    output hit_ack,
    output hit_valid,
    output hit_idx
  );

endinterface

// File: rtl/block_locator.sv
// Registered coordinate to block lookup; lowest
// index wins if spans ever overlap.
module block_locator
  import board_pkg::*;
(
  input  logic        pclk,
  input  logic        reset,
  input  logic        en,
  input  logic [10:0] x,
  input  logic [10:0] y,
  output logic        match,
  output logic [3:0]  idx
);

  logic       col_ok;
  logic       row_ok;
  logic [1:0] col;
  logic [1:0] row;

  // Scan downwards so the lowest match is kept.
  always_comb begin
    col_ok = 1'b0;
    row_ok = 1'b0;
    col    = 2'd0;
    row    = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (in_span(x, hor(2'(i)), B_WIDTH)) begin
        col_ok = 1'b1;
        col    = 2'(i);
      end
      if (in_span(y, ver(2'(i)), B_HEIGHT)) begin
        row_ok = 1'b1;
        row    = 2'(i);
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      match <= 1'b0;
      idx   <= 4'd0;
    end else if (en) begin
      match <= col_ok && row_ok;
      idx   <= {row, col};
    end
  end

endmodule

// File: rtl/board_ctrl.sv
// Destroyed-block mask owner: services hits, commits
// pending hits at vblank start, tracks score/clear.
module board_ctrl
  import board_pkg::*;
(
  input  logic               pclk,
  input  logic               reset,
  input  logic               vblnk_in,
  input  logic               start,
  board_ctrl_if.slave        hit,
  output logic [NBLOCKS-1:0] blocks_out,
  output logic [7:0]         score,
  output logic               level_clear
);

  state_t             state;
  logic [NBLOCKS-1:0] pending;
  logic [NBLOCKS-1:0] blk_busy;
  logic [NBLOCKS-1:0] hit_bit;
  logic [NBLOCKS-1:0] pend_next;
  logic               vblnk_q;
  logic               vb_rise;
  logic               hit_ok;
  logic               loc_en;
  logic               loc_match;
  logic [3:0]         loc_idx;

  assign loc_en = (state == S_IDLE) && hit.hit_req;

  block_locator u_loc (
    .pclk  (pclk),
    .reset (reset || start),
    .en    (loc_en),
    .x     (hit.hit_x),
    .y     (hit.hit_y),
    .match (loc_match),
    .idx   (loc_idx)
  );

  always_comb begin
    blk_busy  = blocks_out | pending;
    hit_ok    = (state == S_LOOKUP) && loc_match
                && !blk_busy[loc_idx];
    hit_bit   = '0;
    if (hit_ok)
      hit_bit[loc_idx] = 1'b1;
    pend_next = pending | hit_bit;
    vb_rise   = vblnk_in && !vblnk_q;
  end

  always_ff @(posedge pclk) begin
    if (reset)
      vblnk_q <= 1'b0;
    else
      vblnk_q <= vblnk_in;
  end

  always_ff @(posedge pclk) begin
    if (reset || start) begin
      state         <= S_IDLE;
      blocks_out    <= '0;
      pending       <= '0;
      score         <= 8'd0;
      level_clear   <= 1'b0;
      hit.hit_ack   <= 1'b0;
      hit.hit_valid <= 1'b0;
      hit.hit_idx   <= 4'd0;
    end else begin
      hit.hit_ack   <= 1'b0;
      hit.hit_valid <= 1'b0;
      hit.hit_idx   <= 4'd0;
      unique case (state)
        S_IDLE: begin
          if (hit.hit_req)
            state <= S_LOOKUP;
        end
        S_LOOKUP: begin
          hit.hit_ack   <= 1'b1;
          hit.hit_valid <= hit_ok;
          hit.hit_idx   <= hit_ok ? loc_idx : 4'd0;
          if (hit_ok && score != 8'hFF)
            score <= score + 8'd1;
          state <= S_RESP;
        end
        default: state <= S_IDLE;
      endcase
      // Same-cycle hit rides along with the commit.
      if (vb_rise) begin
        blocks_out <= blocks_out | pend_next;
        pending    <= '0;
      end else begin
        pending <= pend_next;
      end
      level_clear <= level_clear || (&blocks_out);
    end
  end

endmodule

// File: tb/tb_board_ctrl.sv
// Directed self-checking bench for board_ctrl.
`timescale 1ns/1ps
module tb_board_ctrl;

  logic        pclk = 1'b0;
  logic        reset;
  logic        vblnk_in;
  logic        start;
  logic [15:0] blocks_out;
  logic [7:0]  score;
  logic        level_clear;
  int          errors = 0;
  int          checks = 0;

  board_ctrl_if hit ();

  board_ctrl dut (
    .pclk        (pclk),
    .reset       (reset),
    .vblnk_in    (vblnk_in),
    .start       (start),
    .hit         (hit.slave),
    .blocks_out  (blocks_out),
    .score       (score),
    .level_clear (level_clear)
  );

  always #5 pclk = ~pclk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits for hit_ack, returns edges counted (99 on timeout).
  task automatic wait_ack(output int n);
    n = 99;
    for (int i = 1; i <= 8; i++) begin
      @(posedge pclk);
      #1;
      if (hit.hit_ack) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic finish_req(input string tag, input int n,
                            input logic ev, input logic [3:0] ei,
                            input logic [7:0] es);
    chk({tag, "_lat"}, n, 2);
    chk({tag, "_valid"}, hit.hit_valid, ev);
    chk({tag, "_idx"}, hit.hit_idx, ei);
    chk({tag, "_score"}, score, es);
    hit.hit_req = 1'b0;
    @(posedge pclk);
    #1;
    chk({tag, "_ackpulse"}, hit.hit_ack, 1'b0);
  endtask

  task automatic do_hit(input string tag,
                        input logic [10:0] x, input logic [10:0] y,
                        input logic ev, input logic [3:0] ei,
                        input logic [7:0] es);
    int n;
    @(negedge pclk);
    hit.hit_x   = x;
    hit.hit_y   = y;
    hit.hit_req = 1'b1;
    wait_ack(n);
    finish_req(tag, n, ev, ei, es);
  endtask

  task automatic vblank(input string tag, input logic [15:0] eb);
    @(negedge pclk);
    vblnk_in = 1'b1;
    @(posedge pclk);
    #1;
    chk(tag, blocks_out, eb);
    @(negedge pclk);
    vblnk_in = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge pclk);
    reset = 1'b1;
    repeat (3) @(negedge pclk);
    reset = 1'b0;
  endtask

  initial begin
    int n;
    logic [15:0] exp_b;
    reset       = 1'b1;
    vblnk_in    = 1'b0;
    start       = 1'b0;
    hit.hit_req = 1'b0;
    hit.hit_x   = 11'd0;
    hit.hit_y   = 11'd0;
    do_reset();
    #1;
    chk("rst_blocks", blocks_out, 16'h0000);
    chk("rst_score", score, 8'd0);
    chk("rst_clear", level_clear, 1'b0);
    chk("rst_ack", hit.hit_ack, 1'b0);
    chk("rst_valid", hit.hit_valid, 1'b0);
    chk("rst_idx", hit.hit_idx, 4'd0);

    do_hit("h150", 11'd150, 11'd80, 1'b1, 4'd0, 8'd1);
    chk("h150_nocommit", blocks_out, 16'h0000);
    do_hit("dup150", 11'd150, 11'd80, 1'b0, 4'd0, 8'd1);
    vblank("commit1", 16'h0001);
    do_hit("post_commit", 11'd150, 11'd80, 1'b0, 4'd0, 8'd1);

    do_reset();
    do_hit("edge212", 11'd212, 11'd110, 1'b1, 4'd0, 8'd1);
    do_hit("miss213", 11'd213, 11'd80, 1'b0, 4'd0, 8'd1);
    do_hit("miss250", 11'd250, 11'd80, 1'b0, 4'd0, 8'd1);
    do_hit("edge612", 11'd612, 11'd290, 1'b1, 4'd15, 8'd2);
    do_hit("miss_y", 11'd150, 11'd111, 1'b0, 4'd0, 8'd2);
    vblank("commit2", 16'h8001);

    // Hit decided on the same edge that sees vblank rise.
    @(negedge pclk);
    hit.hit_x   = 11'd262;
    hit.hit_y   = 11'd130;
    hit.hit_req = 1'b1;
    @(posedge pclk);
    @(negedge pclk);
    vblnk_in = 1'b1;
    @(posedge pclk);
    #1;
    chk("samecyc_ack", hit.hit_ack, 1'b1);
    chk("samecyc_valid", hit.hit_valid, 1'b1);
    chk("samecyc_idx", hit.hit_idx, 4'd5);
    chk("samecyc_blocks", blocks_out, 16'h8021);
    hit.hit_req = 1'b0;
    @(negedge pclk);
    vblnk_in = 1'b0;
    @(posedge pclk);

    do_reset();
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        do_hit("centre", 11'(112 + 150 * c + 50),
               11'(60 + 70 * r + 25), 1'b1,
               4'(r * 4 + c), 8'(r * 4 + c + 1));
      end
    end
    chk("all_score", score, 8'd16);
    chk("all_precommit", blocks_out, 16'h0000);
    vblank("all_commit", 16'hFFFF);
    chk("clear_lag", level_clear, 1'b0);
    @(posedge pclk);
    #1;
    chk("clear_set", level_clear, 1'b1);
    repeat (3) @(posedge pclk);
    #1;
    chk("clear_sticky", level_clear, 1'b1);

    @(negedge pclk);
    start = 1'b1;
    @(posedge pclk);
    #1;
    chk("start_blocks", blocks_out, 16'h0000);
    chk("start_score", score, 8'd0);
    chk("start_clear", level_clear, 1'b0);
    @(negedge pclk);
    start = 1'b0;

    // start while in LOOKUP; held request is re-serviced.
    @(negedge pclk);
    hit.hit_x   = 11'd412;
    hit.hit_y   = 11'd200;
    hit.hit_req = 1'b1;
    @(posedge pclk);
    @(negedge pclk);
    start = 1'b1;
    @(posedge pclk);
    #1;
    chk("startlk_noack", hit.hit_ack, 1'b0);
    chk("startlk_score", score, 8'd0);
    @(negedge pclk);
    start = 1'b0;
    wait_ack(n);
    finish_req("startlk_retry", n, 1'b1, 4'd10, 8'd1);

    // reset while in LOOKUP; held request is re-serviced.
    @(negedge pclk);
    hit.hit_x   = 11'd562;
    hit.hit_y   = 11'd60;
    hit.hit_req = 1'b1;
    @(posedge pclk);
    @(negedge pclk);
    reset = 1'b1;
    @(posedge pclk);
    #1;
    chk("rstlk_noack", hit.hit_ack, 1'b0);
    chk("rstlk_score", score, 8'd0);
    @(negedge pclk);
    reset = 1'b0;
    wait_ack(n);
    finish_req("rstlk_retry", n, 1'b1, 4'd3, 8'd1);
    exp_b = 16'h0008;
    vblank("rstlk_commit", exp_b);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
